// File: rtl/sdu_display.sv
// Storage and display unit: 8x4-bit queue storage with a combinational read port,
// plus a registered scan of the valid entries onto an 8-digit active-low seven-segment display.
module sdu_display #(
   parameter int SCAN_DIV = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       we,
   input  logic [2:0] wa,
   input  logic [3:0] wd,
   input  logic [2:0] ra,
   output logic [3:0] rd,
   input  logic [7:0] valid,
   input  logic [2:0] p,
   output logic [7:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DivW-1:0] DivMax = DivW'(SCAN_DIV - 1);

   logic [3:0]      mem_q [8];
   logic [DivW-1:0] div_q, div_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      an_q, an_d;
   logic [6:0]      seg_q, seg_d;
   logic            dp_q, dp_d;
   logic [3:0]      curEntry;
   logic [6:0]      fontSeg;

   // Queue storage; writes are blocked while reset is held.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) mem_q[i] <= 4'd0;
      end else if (we) begin
         mem_q[wa] <= wd;
      end
   end

   assign rd = mem_q[ra];

   // Dwell counter; the digit index advances on the last cycle of each dwell.
   always_comb begin
      div_d = div_q;
      idx_d = idx_q;
      if (div_q == DivMax) begin
         div_d = '0;
         idx_d = idx_q + 3'd1;
      end else begin
         div_d = div_q + DivW'(1);
      end
   end

   always_comb begin
      curEntry = mem_q[idx_q];
      fontSeg  = 7'h7F;
      case (curEntry)
         4'h0: fontSeg = 7'h40;
         4'h1: fontSeg = 7'h79;
         4'h2: fontSeg = 7'h24;
         4'h3: fontSeg = 7'h30;
         4'h4: fontSeg = 7'h19;
         4'h5: fontSeg = 7'h12;
         4'h6: fontSeg = 7'h02;
         4'h7: fontSeg = 7'h78;
         4'h8: fontSeg = 7'h00;
         4'h9: fontSeg = 7'h10;
         4'hA: fontSeg = 7'h08;
         4'hB: fontSeg = 7'h03;
         4'hC: fontSeg = 7'h46;
         4'hD: fontSeg = 7'h21;
         4'hE: fontSeg = 7'h06;
         4'hF: fontSeg = 7'h0E;
         default: fontSeg = 7'h7F;
      endcase
   end

   // Outputs are built from the pre-edge index so an, seg and dp always switch together.
   always_comb begin
      an_d  = ~(8'b1 << idx_q);
      seg_d = valid[idx_q] ? fontSeg : 7'h7F;
      dp_d  = ~(valid[idx_q] && (idx_q == p));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= '0;
         idx_q <= 3'd0;
         an_q  <= 8'hFF;
         seg_q <= 7'h7F;
         dp_q  <= 1'b1;
      end else begin
         div_q <= div_d;
         idx_q <= idx_d;
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_sdu_display.sv
// Scoreboard bench for sdu_display with SCAN_DIV=4: a behavioural model pushes the
// expected display word before each edge and every scenario pops and compares after it.
module tb_sdu_display;

   localparam int Div = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       we = 1'b0;
   logic [2:0] wa = 3'd0;
   logic [3:0] wd = 4'd0;
   logic [2:0] ra = 3'd0;
   logic [3:0] rd;
   logic [7:0] valid = 8'h00;
   logic [2:0] p = 3'd0;
   logic [7:0] an;
   logic [6:0] seg;
   logic       dp;

   typedef struct packed {
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   exp_t sbq [$];
   exp_t exp;
   int   checks = 0;
   int   errors = 0;

   logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   logic [3:0] mMem [8];
   int         mDiv;
   int         mIdx;

   sdu_display #(.SCAN_DIV(Div)) dut (
      .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd),
      .valid(valid), .p(p), .an(an), .seg(seg), .dp(dp)
   );

   always #5 clk = ~clk;

   // Expected output word for the coming edge, from the model state and current inputs.
   function automatic exp_t predict();
      exp_t e;
      if (rst) begin
         e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1;
      end else begin
         e.an = 8'hFF;
         e.an[mIdx] = 1'b0;
         e.seg = valid[mIdx] ? font[mMem[mIdx]] : 7'h7F;
         e.dp  = !(valid[mIdx] && (mIdx == int'(p)));
      end
      return e;
   endfunction

   // Push the expectation, advance the model across one edge, then wait past the edge.
   task automatic applyStimulus();
      sbq.push_back(predict());
      if (rst) begin
         for (int i = 0; i < 8; i++) mMem[i] = 4'd0;
         mDiv = 0;
         mIdx = 0;
      end else begin
         if (we) mMem[wa] = wd;
         if (mDiv == Div - 1) begin
            mDiv = 0;
            mIdx = (mIdx + 1) % 8;
         end else begin
            mDiv++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         applyStimulus();
         exp = sbq.pop_front(); checks++;
         if ({an, seg, dp} !== {exp.an, exp.seg, exp.dp}) begin
            errors++;
            $display("[TB] FAIL reset_hold got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b", an, seg, dp, exp.an, exp.seg, exp.dp);
         end
      end
      rst = 1'b0;
      valid = 8'h00;
      for (int c = 0; c < 8 * Div + 1; c++) begin
         applyStimulus();
         exp = sbq.pop_front(); checks++;
         if ({an, seg, dp} !== {exp.an, exp.seg, exp.dp}) begin
            errors++;
            $display("[TB] FAIL empty_scan cyc=%0d got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b", c, an, seg, dp, exp.an, exp.seg, exp.dp);
         end
         if (c == 0 || c == 8 * Div) begin
            checks++;
            if (an !== 8'hFE) begin
               errors++;
               $display("[TB] FAIL first_digit cyc=%0d got an=%h want an=fe", c, an);
            end
         end
         if (c == Div) begin
            checks++;
            if (an !== 8'hFD) begin
               errors++;
               $display("[TB] FAIL second_digit got an=%h want an=fd", an);
            end
         end
      end
   endtask

   task automatic test_write_read();
      we = 1'b1; wa = 3'd3; wd = 4'hA;
      applyStimulus();
      exp = sbq.pop_front(); checks++;
      if ({an, seg, dp} !== {exp.an, exp.seg, exp.dp}) begin
         errors++;
         $display("[TB] FAIL wr_scan got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b", an, seg, dp, exp.an, exp.seg, exp.dp);
      end
      we = 1'b0; ra = 3'd3;
      #1;
      checks++;
      if (rd !== 4'hA) begin
         errors++;
         $display("[TB] FAIL read_a got rd=%h want rd=a", rd);
      end
      we = 1'b1; wa = 3'd3; wd = 4'h5;
      #1;
      checks++;
      if (rd !== 4'hA) begin
         errors++;
         $display("[TB] FAIL read_before_edge got rd=%h want rd=a", rd);
      end
      applyStimulus();
      we = 1'b0;
      exp = sbq.pop_front(); checks++;
      if ({an, seg, dp} !== {exp.an, exp.seg, exp.dp}) begin
         errors++;
         $display("[TB] FAIL wr_scan2 got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b", an, seg, dp, exp.an, exp.seg, exp.dp);
      end
      checks++;
      if (rd !== 4'h5) begin
         errors++;
         $display("[TB] FAIL read_after_edge got rd=%h want rd=5", rd);
      end
   endtask

   task automatic test_display();
      logic [3:0] vals [3] = '{4'h1, 4'h2, 4'hF};
      for (int i = 0; i < 3; i++) begin
         we = 1'b1; wa = 3'(i); wd = vals[i];
         applyStimulus();
         void'(sbq.pop_front());
      end
      we = 1'b0; valid = 8'b0000_0111; p = 3'd0;
      for (int c = 0; c < 8 * Div + 2; c++) begin
         applyStimulus();
         exp = sbq.pop_front(); checks++;
         if ({an, seg, dp} !== {exp.an, exp.seg, exp.dp}) begin
            errors++;
            $display("[TB] FAIL disp_scan cyc=%0d got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b", c, an, seg, dp, exp.an, exp.seg, exp.dp);
         end
         if (c > 0 && an == 8'hFE) begin
            checks++;
            if (seg !== 7'h79 || dp !== 1'b0) begin
               errors++;
               $display("[TB] FAIL disp_digit0 got seg=%h dp=%b want seg=79 dp=0", seg, dp);
            end
         end else if (c > 0 && an == 8'hFD) begin
            checks++;
            if (seg !== 7'h24 || dp !== 1'b1) begin
               errors++;
               $display("[TB] FAIL disp_digit1 got seg=%h dp=%b want seg=24 dp=1", seg, dp);
            end
         end else if (c > 0 && an == 8'hFB) begin
            checks++;
            if (seg !== 7'h0E || dp !== 1'b1) begin
               errors++;
               $display("[TB] FAIL disp_digit2 got seg=%h dp=%b want seg=0e dp=1", seg, dp);
            end
         end else if (c > 0) begin
            checks++;
            if (seg !== 7'h7F || dp !== 1'b1) begin
               errors++;
               $display("[TB] FAIL disp_blank an=%h got seg=%h dp=%b want seg=7f dp=1", an, seg, dp);
            end
         end
      end
   endtask

   task automatic test_head_wrap();
      we = 1'b1; wa = 3'd7; wd = 4'h8;
      applyStimulus();
      void'(sbq.pop_front());
      wa = 3'd0; wd = 4'hC;
      applyStimulus();
      void'(sbq.pop_front());
      we = 1'b0; valid = 8'b1000_0001; p = 3'd7;
      applyStimulus();
      void'(sbq.pop_front());
      for (int c = 0; c < 8 * Div + 2; c++) begin
         applyStimulus();
         exp = sbq.pop_front(); checks++;
         if ({an, seg, dp} !== {exp.an, exp.seg, exp.dp}) begin
            errors++;
            $display("[TB] FAIL head_scan cyc=%0d got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b", c, an, seg, dp, exp.an, exp.seg, exp.dp);
         end
         if (an == 8'h7F) begin
            checks++;
            if (seg !== 7'h00 || dp !== 1'b0) begin
               errors++;
               $display("[TB] FAIL head_digit7 got seg=%h dp=%b want seg=00 dp=0", seg, dp);
            end
         end else if (an == 8'hFE) begin
            checks++;
            if (seg !== 7'h46 || dp !== 1'b1) begin
               errors++;
               $display("[TB] FAIL head_digit0 got seg=%h dp=%b want seg=46 dp=1", seg, dp);
            end
         end
      end
   endtask

   task automatic test_write_dwell();
      int budget;
      valid = 8'b0000_0111; p = 3'd0;
      we = 1'b1; wa = 3'd2; wd = 4'hF;
      applyStimulus();
      void'(sbq.pop_front());
      we = 1'b0;
      budget = 0;
      while (an !== 8'hFB && budget < 10 * Div) begin
         applyStimulus();
         budget++;
         exp = sbq.pop_front(); checks++;
         if ({an, seg, dp} !== {exp.an, exp.seg, exp.dp}) begin
            errors++;
            $display("[TB] FAIL dwell_wait got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b", an, seg, dp, exp.an, exp.seg, exp.dp);
         end
      end
      checks++;
      if (an !== 8'hFB) begin
         errors++;
         $display("[TB] FAIL dwell_timeout got an=%h want an=fb", an);
      end
      we = 1'b1; wa = 3'd2; wd = 4'h6;
      applyStimulus();
      we = 1'b0;
      exp = sbq.pop_front(); checks++;
      if ({an, seg, dp} !== {exp.an, exp.seg, exp.dp} || seg !== 7'h0E) begin
         errors++;
         $display("[TB] FAIL dwell_write_edge got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b", an, seg, dp, exp.an, exp.seg, exp.dp);
      end
      applyStimulus();
      exp = sbq.pop_front(); checks++;
      if ({an, seg, dp} !== {exp.an, exp.seg, exp.dp} || an !== 8'hFB || seg !== 7'h02) begin
         errors++;
         $display("[TB] FAIL dwell_update got an=%h seg=%h want an=fb seg=02", an, seg);
      end
   endtask

   task automatic test_reset_mid();
      int budget;
      budget = 0;
      while (mIdx != 5 && budget < 10 * Div) begin
         applyStimulus();
         budget++;
         void'(sbq.pop_front());
      end
      applyStimulus();
      void'(sbq.pop_front());
      checks++;
      if (mIdx != 5) begin
         errors++;
         $display("[TB] FAIL midreset_timeout got idx=%0d want idx=5", mIdx);
      end
      rst = 1'b1; we = 1'b1; wa = 3'd4; wd = 4'h7;
      applyStimulus();
      exp = sbq.pop_front(); checks++;
      if ({an, seg, dp} !== {exp.an, exp.seg, exp.dp} || an !== 8'hFF) begin
         errors++;
         $display("[TB] FAIL midreset got an=%h seg=%h dp=%b want an=ff seg=7f dp=1", an, seg, dp);
      end
      rst = 1'b0; we = 1'b0; valid = 8'h5A; p = 3'd0;
      for (int c = 0; c < 8 * Div; c++) begin
         applyStimulus();
         exp = sbq.pop_front(); checks++;
         if ({an, seg, dp} !== {exp.an, exp.seg, exp.dp}) begin
            errors++;
            $display("[TB] FAIL post_reset cyc=%0d got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b", c, an, seg, dp, exp.an, exp.seg, exp.dp);
         end
         if (c == 0) begin
            checks++;
            if (an !== 8'hFE || seg !== 7'h7F) begin
               errors++;
               $display("[TB] FAIL post_reset_first got an=%h seg=%h want an=fe seg=7f", an, seg);
            end
         end
         if (an == 8'hEF) begin
            checks++;
            if (seg !== 7'h40) begin
               errors++;
               $display("[TB] FAIL reset_blocks_write got seg=%h want seg=40", seg);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mMem[i] = 4'd0;
      mDiv = 0;
      mIdx = 0;
      test_reset();
      test_write_read();
      test_display();
      test_head_wrap();
      test_write_dwell();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sdu_display.md
# sdu_display

Storage and display unit for the 8-entry, 4-bit queue. It holds the queue data written by the list control unit and serves its read port. It also scans the stored entries onto an 8-digit multiplexed seven-segment display. Only entries flagged valid are shown, and the head entry is marked with the decimal point.

## Interface

Parameters:
- SCAN_DIV, 100000: clk cycles per displayed digit; legal range ≥ 2; counter width is ceil(log2(SCAN_DIV)).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: synchronous, active-high.
- we  input  1  write strobe, one cycle wide.
- wa  input  3  write address.
- wd  input  4  write data.
- ra  input  3  read address.
- rd  output  4  read data, combinational from storage.
- valid  input  8  per-entry occupancy flags; bit i is set when entry i holds queue data.
- p  input  3  head (read pointer) index.
- an  output  8  digit enables, active-low; bit i drives digit i.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.

## Operation

- **Storage**: mem[0..7] × 4 bits, all entries writable.
  - Posedge clk with we=1: mem[wa] ← wd.
  - we=0: storage holds.
- **Read**: rd = mem[ra], combinational.
  - Same-address write and read: rd shows the old value until the write edge, then the new value.
- **Scan state**:
  - div counter counts 0..SCAN_DIV-1.
  - idx is a 3-bit digit index.
  - Each cycle: if div == SCAN_DIV-1 then div ← 0 and idx ← idx+1 (7 wraps to 0); else div ← div+1.
- **Display outputs**: registered every cycle from the current idx, valid and p.
  - an ← ~(8'b1 << idx).
  - seg ← hex(mem[idx]) if valid[idx]; otherwise 7'h7F (blank).
  - dp ← 0 if (idx == p and valid[idx]); otherwise 1.
- **Hex font** (active-low gfedcba):
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78.
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E (all hex).
- **Empty queue** (valid == 0): every digit blank and dp=1; an keeps scanning.
- The block never modifies valid or p. Those signals are owned by the control unit.

## Timing

- **Reset** (posedge clk with rst=1):
  - mem all 0.
  - div=0, idx=0.
  - an=8'hFF, seg=7'h7F, dp=1.
- Writes are ignored on any cycle with rst=1.
- Reset mid-scan returns to idx=0 and div=0 on the same edge.
- **First edge after reset release**: an=8'hFE, with seg/dp reflecting entry 0.
- **Write-to-display latency**:
  - An entry written at edge N appears on seg at edge N+1, provided idx addresses it at edge N+1.
  - A valid or p change follows the same one-edge latency.
- **Digit dwell**: each digit is enabled for exactly SCAN_DIV cycles. A full frame is 8×SCAN_DIV cycles.
- **Output lag**: outputs lag idx by one clk; an, seg and dp always change on the same edge (no cross-digit glitch).
- **Simultaneous events**: write, idx advance and valid change on the same edge all take effect together. The next registered output uses the post-edge values.

## Test plan

All scenarios use SCAN_DIV=4.

1. **Reset**: rst=1 for 2 cycles → an=FF, seg=7F, dp=1. Then release with valid=0 → an steps FE, FD, … every 4 cycles, seg=7F and dp=1 throughout, wrapping from 7F back to FE after 32 cycles.
2. **Write/read**: we=1, wa=3, wd=A; next cycle ra=3 → rd=A. Write wa=3, wd=5 with ra=3 held → rd changes A→5 exactly at the write edge.
3. **Display of valid entries**:
   - Setup: mem[0..2]=1,2,F; valid=8'b0000_0111; p=0.
   - Digit 0 → seg=79, dp=0.
   - Digit 1 → seg=24, dp=1.
   - Digit 2 → seg=0E, dp=1.
   - Digits 3..7 → seg=7F.
4. **Head move and wrap**: valid=8'b1000_0001, p=7, mem[7]=8, mem[0]=C → digit 7 shows seg=00 with dp=0; digit 0 shows seg=46 with dp=1.
5. **Write during a digit's dwell**: while an=FB (digit 2), write wa=2, wd=6 → seg becomes 02 one edge after the write, and an stays FB.
6. **Reset mid-scan**: assert rst while idx=5 and mem is nonzero → next edge an=FF; after release an=FE, and every digit shows blank or 40 per valid.
